// File: rtl/r2r_pkg.sv
// Shared types and mode-ordering helpers for the R2R display mode controller.
// Provides the data-select encoding, the controller FSM states and next-mode functions.
package r2r_pkg;

  typedef enum logic [1:0] {
    SEL_OFF    = 2'b00,
    SEL_RAW    = 2'b01,
    SEL_AVG    = 2'b10,
    SEL_SCALED = 2'b11
  } r2r_sel_t;

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_BLANK = 2'b01,
    S_SHOW  = 2'b10
  } r2r_ctrl_state_t;

  // OFF -> RAW -> AVG -> SCALED -> OFF
  function automatic r2r_sel_t next_manual(input r2r_sel_t s);
    r2r_sel_t r;
    unique case (s)
      SEL_OFF:    r = SEL_RAW;
      SEL_RAW:    r = SEL_AVG;
      SEL_AVG:    r = SEL_SCALED;
      SEL_SCALED: r = SEL_OFF;
      default:    r = SEL_OFF;
    endcase
    return r;
  endfunction

  // RAW -> AVG -> SCALED -> RAW; auto-cycling never lands on OFF
  function automatic r2r_sel_t next_auto(input r2r_sel_t s);
    r2r_sel_t r;
    unique case (s)
      SEL_RAW:    r = SEL_AVG;
      SEL_AVG:    r = SEL_SCALED;
      SEL_SCALED: r = SEL_RAW;
      default:    r = SEL_RAW;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/r2r_interval_timer.sv
// Loadable saturating down-counter; expire flags the last enabled cycle of the interval.
// Ports: clk, reset (async high), load (reload LOAD_VAL), enable (count), expire.
module r2r_interval_timer #(
  parameter int LOAD_VAL = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(LOAD_VAL + 1);
  localparam logic [W-1:0] LOAD_V = W'(LOAD_VAL);
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0] r_cnt;

  // Expiry is the LOAD_VAL-th enabled cycle after a load.
  assign expire = enable && (r_cnt == ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= LOAD_V;
    end else if (enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

endmodule

// File: rtl/r2r_display_mode_ctrl.sv
// R2R measurement select sequencer: mode stepping, post-change blanking, display strobes.
// Ports: clk, reset, mode_next, auto_en, hold, sample_valid -> data_select, display_update, blanking, mode_changed.
module r2r_display_mode_ctrl
  import r2r_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int BLANK_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_next,
  input  logic       auto_en,
  input  logic       hold,
  input  logic       sample_valid,
  output logic [1:0] data_select,
  output logic       display_update,
  output logic       blanking,
  output logic       mode_changed
);

  r2r_ctrl_state_t r_state, w_state;
  r2r_sel_t        r_sel, w_sel, w_nsel;
  logic            r_upd, w_upd;
  logic            r_blank, w_blank;
  logic            r_mc, w_mc;

  logic w_blank_load, w_blank_en, w_blank_exp;
  logic w_dwell_load, w_dwell_en, w_dwell_exp;
  logic w_auto, w_chg;

  assign w_blank_en = (r_state == S_BLANK);
  assign w_dwell_en = (r_state == S_SHOW) && auto_en && !hold;
  // Held in reload outside S_SHOW so every entry starts a fresh dwell.
  assign w_dwell_load = (r_state != S_SHOW) || !auto_en;

  assign w_auto = (r_state == S_SHOW) && w_dwell_exp;
  assign w_chg  = mode_next || w_auto;
  // Manual order takes precedence when both triggers coincide.
  assign w_nsel = mode_next ? next_manual(r_sel) : next_auto(r_sel);

  r2r_interval_timer #(.LOAD_VAL(BLANK_CYCLES)) u_blank_tmr (
    .clk    (clk),
    .reset  (reset),
    .load   (w_blank_load),
    .enable (w_blank_en),
    .expire (w_blank_exp)
  );

  r2r_interval_timer #(.LOAD_VAL(DWELL_CYCLES)) u_dwell_tmr (
    .clk    (clk),
    .reset  (reset),
    .load   (w_dwell_load),
    .enable (w_dwell_en),
    .expire (w_dwell_exp)
  );

  always_comb begin
    w_state      = r_state;
    w_sel        = r_sel;
    w_upd        = 1'b0;
    w_blank      = 1'b0;
    w_mc         = 1'b0;
    w_blank_load = 1'b0;
    if (w_chg) begin
      // A mode change swallows any coincident sample.
      w_sel = w_nsel;
      w_mc  = 1'b1;
      if (w_nsel == SEL_OFF) begin
        w_state = S_OFF;
        w_upd   = 1'b1;
      end else begin
        w_state      = S_BLANK;
        w_blank      = 1'b1;
        w_blank_load = 1'b1;
      end
    end else begin
      unique case (r_state)
        S_OFF: begin
        end
        S_BLANK: begin
          if (w_blank_exp) begin
            w_state = S_SHOW;
          end else begin
            w_blank = 1'b1;
          end
        end
        S_SHOW: begin
          w_upd = sample_valid && !hold;
        end
        default: begin
          w_state = S_OFF;
          w_sel   = SEL_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_OFF;
      r_sel   <= SEL_OFF;
      r_upd   <= 1'b0;
      r_blank <= 1'b0;
      r_mc    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_upd   <= w_upd;
      r_blank <= w_blank;
      r_mc    <= w_mc;
    end
  end

  assign data_select    = r_sel;
  assign display_update = r_upd;
  assign blanking       = r_blank;
  assign mode_changed   = r_mc;

endmodule

// File: tb/tb_r2r_display_mode_ctrl.sv
// Self-checking bench for r2r_display_mode_ctrl (DWELL=8, BLANK=3).
// Vector table, directed multi-cycle sequences and randomized traffic vs a reference model.
module tb_r2r_display_mode_ctrl;

  localparam int D = 8;
  localparam int B = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_next = 1'b0;
  logic       auto_en = 1'b0;
  logic       hold = 1'b0;
  logic       sample_valid = 1'b0;
  logic [1:0] data_select;
  logic       display_update;
  logic       blanking;
  logic       mode_changed;

  int checks = 0;
  int failures = 0;

  r2r_display_mode_ctrl #(
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .mode_next      (mode_next),
    .auto_en        (auto_en),
    .hold           (hold),
    .sample_valid   (sample_valid),
    .data_select    (data_select),
    .display_update (display_update),
    .blanking       (blanking),
    .mode_changed   (mode_changed)
  );

  always #5 clk = ~clk;

  // Reference model: mode as 0..3, blanking cycles left, dwell cycles counted up.
  int m_mode, m_blank_left, m_dwell;
  bit m_upd, m_mc;

  task automatic model_reset();
    m_mode = 0; m_blank_left = 0; m_dwell = 0;
    m_upd = 0; m_mc = 0;
  endtask

  task automatic model_step(input bit mn, ae, hd, sv);
    bit off, blank, show, expiry;
    off    = (m_mode == 0);
    blank  = !off && (m_blank_left > 0);
    show   = !off && !blank;
    expiry = show && ae && !hd && (m_dwell + 1 >= D);
    m_upd = 0; m_mc = 0;
    if (mn || expiry) begin
      m_mode = mn ? (m_mode + 1) % 4 : (m_mode % 3) + 1;
      m_mc = 1;
      m_dwell = 0;
      if (m_mode == 0) begin
        m_blank_left = 0;
        m_upd = 1;
      end else begin
        m_blank_left = B;
      end
    end else if (blank) begin
      m_blank_left--;
      m_dwell = 0;
    end else if (show) begin
      if (!ae) m_dwell = 0;
      else if (!hd) m_dwell++;
      if (sv && !hd) m_upd = 1;
    end
  endtask

  function automatic bit [4:0] model_out();
    bit bl;
    bl = (m_mode != 0) && (m_blank_left > 0);
    return {2'(m_mode), m_upd, bl, m_mc};
  endfunction

  function automatic bit [4:0] dut_out();
    return {data_select, display_update, blanking, mode_changed};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit mn, ae, hd, sv);
    mode_next = mn; auto_en = ae; hold = hd; sample_valid = sv;
    @(posedge clk);
    model_step(mn, ae, hd, sv);
    #1;
    check("model", dut_out(), model_out());
    mode_next = 0; sample_valid = 0;
  endtask

  task automatic do_reset();
    mode_next = 0; auto_en = 0; hold = 0; sample_valid = 0;
    reset = 1;
    @(posedge clk);
    #1;
    check("reset_state", dut_out(), 5'b0);
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    bit mn, ae, hd, sv;
    bit [1:0] sel;
    bit upd, blank, mc;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t v(bit mn, bit ae, bit hd, bit sv,
                             bit [1:0] sel, bit upd, bit bl, bit mc);
    vec_t r;
    r.mn = mn; r.ae = ae; r.hd = hd; r.sv = sv;
    r.sel = sel; r.upd = upd; r.blank = bl; r.mc = mc;
    return r;
  endfunction

  initial begin
    vecs[0]  = v(0,0,0,0, 2'd0,0,0,0);
    vecs[1]  = v(1,0,0,0, 2'd1,0,1,1);
    vecs[2]  = v(0,0,0,1, 2'd1,0,1,0);
    vecs[3]  = v(0,0,0,0, 2'd1,0,1,0);
    vecs[4]  = v(0,0,0,0, 2'd1,0,0,0);
    vecs[5]  = v(0,0,0,1, 2'd1,1,0,0);
    vecs[6]  = v(0,0,1,1, 2'd1,0,0,0);
    vecs[7]  = v(1,0,0,0, 2'd2,0,1,1);
    vecs[8]  = v(0,0,0,0, 2'd2,0,1,0);
    vecs[9]  = v(1,0,0,0, 2'd3,0,1,1);
    vecs[10] = v(0,0,0,0, 2'd3,0,1,0);
    vecs[11] = v(0,0,0,0, 2'd3,0,1,0);
    vecs[12] = v(0,0,0,0, 2'd3,0,0,0);
    vecs[13] = v(0,0,0,1, 2'd3,1,0,0);
    vecs[14] = v(1,0,0,1, 2'd0,1,0,1);
    vecs[15] = v(0,0,0,1, 2'd0,0,0,0);
    vecs[16] = v(0,1,1,1, 2'd0,0,0,0);
    vecs[17] = v(1,0,0,0, 2'd1,0,1,1);
    vecs[18] = v(1,0,0,0, 2'd2,0,1,1);
    vecs[19] = v(0,0,0,0, 2'd2,0,1,0);
    vecs[20] = v(0,0,0,0, 2'd2,0,1,0);
    vecs[21] = v(0,0,0,0, 2'd2,0,0,0);

    // Vector table
    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].mn, vecs[i].ae, vecs[i].hd, vecs[i].sv);
      check($sformatf("vec%0d", i), dut_out(),
            {vecs[i].sel, vecs[i].upd, vecs[i].blank, vecs[i].mc});
    end

    // Auto-cycling: RAW -> AVG -> SCALED -> RAW, dwell 8 after each show entry
    do_reset();
    step(1, 1, 0, 0);
    check("auto_first", dut_out(), {2'd1, 1'b0, 1'b1, 1'b1});
    for (int k = 1; k <= 34; k++) begin
      int es;
      bit eb, em;
      step(0, 1, 0, 0);
      es = (k < 11) ? 1 : (k < 22) ? 2 : (k < 33) ? 3 : 1;
      em = (k == 11) || (k == 22) || (k == 33);
      eb = (k <= 2) || (k >= 11 && k <= 13) ||
           (k >= 22 && k <= 24) || (k >= 33);
      check($sformatf("auto_k%0d", k), dut_out(),
            {2'(es), 1'b0, eb, em});
    end

    // Hold pauses the dwell timer and suppresses strobes
    do_reset();
    step(1, 1, 0, 0);
    for (int k = 1; k <= 31; k++) begin
      bit hd;
      hd = (k >= 8) && (k <= 27);
      step(0, 1, hd, hd);
      if (k >= 3) begin
        check($sformatf("hold_k%0d", k), dut_out(),
              {(k == 31) ? 2'd2 : 2'd1, 1'b0, k == 31, k == 31});
      end
    end

    // Coincident mode_next and dwell expiry in AVG, then mode_next while blanking
    do_reset();
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    check("coinc_avg", dut_out(), {2'd3, 1'b0, 1'b1, 1'b1});
    step(1, 1, 0, 0);
    check("blank_to_off", dut_out(), {2'd0, 1'b1, 1'b0, 1'b1});
    step(0, 1, 0, 1);
    check("off_single_upd", dut_out(), {2'd0, 1'b0, 1'b0, 1'b0});

    // Coincidence in SCALED: manual order wins, so OFF rather than RAW
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int k = 1; k <= 10; k++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("coinc_scaled", dut_out(), {2'd0, 1'b1, 1'b0, 1'b1});

    // Asynchronous reset mid-blank
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    #2 reset = 1;
    #1 check("async_reset", dut_out(), 5'b0);
    #2 reset = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 1);
      check($sformatf("post_reset%0d", k), dut_out(), 5'b0);
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      bit mn, ae, hd, sv;
      if ($urandom_range(0, 799) == 0) do_reset();
      mn = ($urandom_range(0, 19) == 0);
      ae = ($urandom_range(0, 3) != 0);
      hd = ($urandom_range(0, 7) == 0);
      sv = ($urandom_range(0, 2) == 0);
      step(mn, ae, hd, sv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
